// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and elaboration helpers for the
// CNN front-end sliding-window sequencing.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } win_state_e;

  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int win_count(
    input int w,
    input int h,
    input int s
  );
    return ((w - 3) / s + 1) * ((h - 3) / s + 1);
  endfunction

endpackage

// File: rtl/raster_pos_counter.sv
// raster_pos_counter: raster row/col position, stride phases
// and output-map coordinates for the sliding-window controller.
module raster_pos_counter
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int STRIDE = 1
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iAdv,
  output logic                      oHit,
  output logic                      oLast,
  output logic [coord_w(IMG_H)-1:0] oOutRow,
  output logic [coord_w(IMG_W)-1:0] oOutCol
);

  localparam int RW = coord_w(IMG_H);
  localparam int CW = coord_w(IMG_W);

  logic [RW-1:0] r_row;
  logic [RW-1:0] r_orow;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_ocol;
  logic          r_rph;
  logic          r_cph;

  logic w_col_end;
  logic w_row_end;
  logic w_rph_nxt;
  logic w_cph_nxt;
  logic w_rwrap;
  logic w_cwrap;

  assign w_col_end = (r_col == CW'(IMG_W - 1));
  assign w_row_end = (r_row == RW'(IMG_H - 1));

  // Phase is a single toggle bit: STRIDE is only ever 1 or 2.
  assign w_rph_nxt = (STRIDE == 2) ? ~r_rph : 1'b0;
  assign w_cph_nxt = (STRIDE == 2) ? ~r_cph : 1'b0;
  assign w_rwrap   = (STRIDE == 1) || r_rph;
  assign w_cwrap   = (STRIDE == 1) || r_cph;

  assign oLast   = w_col_end && w_row_end;
  assign oHit    = (r_row >= RW'(2)) && (r_col >= CW'(2))
                && !r_rph && !r_cph;
  assign oOutRow = r_orow;
  assign oOutCol = r_ocol;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_orow <= '0;
      r_ocol <= '0;
      r_rph  <= 1'b0;
      r_cph  <= 1'b0;
    end else if (iAdv) begin
      if (w_col_end) begin
        r_col  <= '0;
        r_cph  <= 1'b0;
        r_ocol <= '0;
        if (w_row_end) begin
          r_row  <= '0;
          r_rph  <= 1'b0;
          r_orow <= '0;
        end else begin
          r_row <= r_row + RW'(1);
          if (r_row >= RW'(2)) begin
            r_rph <= w_rph_nxt;
            if (w_rwrap) r_orow <= r_orow + RW'(1);
          end
        end
      end else begin
        r_col <= r_col + CW'(1);
        if (r_col >= CW'(2)) begin
          r_cph <= w_cph_nxt;
          if (w_cwrap) r_ocol <= r_ocol + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sliding_window_ctrl.sv
// sliding_window_ctrl: frame FSM, pixel handshake and
// window-valid registers for the 3x3 sliding-window datapath.
module sliding_window_ctrl
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int PIX_W  = 8,
  parameter int STRIDE = 1
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic                      iStart,
  output logic                      oBusy,
  input  logic [PIX_W-1:0]          iPixelIn,
  input  logic                      iPixelValid,
  output logic                      oPixelReady,
  output logic [PIX_W-1:0]          oWinPixel,
  output logic                      oWinPixelValid,
  output logic                      oWinValid,
  output logic [coord_w(IMG_H)-1:0] oWinRow,
  output logic [coord_w(IMG_W)-1:0] oWinCol,
  input  logic                      iWinReady,
  output logic                      oFrameDone
);

  localparam int RW = coord_w(IMG_H);
  localparam int CW = coord_w(IMG_W);

  if (STRIDE != 1 && STRIDE != 2) begin : g_bad_stride
    $error("sliding_window_ctrl: STRIDE must be 1 or 2");
  end

  win_state_e r_state;
  win_state_e w_state_nxt;

  logic          r_win_valid;
  logic [RW-1:0] r_win_row;
  logic [CW-1:0] r_win_col;
  logic          r_done;

  logic          w_accept;
  logic          w_hit;
  logic          w_last;
  logic          w_done_nxt;
  logic [RW-1:0] w_orow;
  logic [CW-1:0] w_ocol;

  // A stalled window freezes intake so the datapath keeps it.
  assign oPixelReady    = (r_state == STREAM)
                       && !(r_win_valid && !iWinReady);
  assign w_accept       = iPixelValid && oPixelReady;
  assign oWinPixel      = iPixelIn;
  assign oWinPixelValid = w_accept;

  raster_pos_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .STRIDE (STRIDE)
  ) u_pos (
    .iClk    (iClk),
    .iRst    (iRst),
    .iAdv    (w_accept),
    .oHit    (w_hit),
    .oLast   (w_last),
    .oOutRow (w_orow),
    .oOutCol (w_ocol)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (iStart) w_state_nxt = STREAM;
      end
      STREAM: begin
        if (w_accept && w_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!r_win_valid || iWinReady) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_accept) begin
        r_win_valid <= w_hit;
        if (w_hit) begin
          r_win_row <= w_orow;
          r_win_col <= w_ocol;
        end
      end else if (iWinReady) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  assign oWinValid  = r_win_valid;
  assign oWinRow    = r_win_row;
  assign oWinCol    = r_win_col;
  assign oFrameDone = r_done;
  assign oBusy      = (r_state != IDLE) || r_done;

endmodule

// File: tb/tb_sliding_window_ctrl.sv
// tb_sliding_window_ctrl: random-stimulus bench for the
// sliding-window controller at stride 1 and stride 2.
module tb_sliding_window_ctrl;

  localparam int W = 28;
  localparam int H = 28;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pv = 1'b0;
  logic       wr = 1'b1;
  logic [7:0] pix = '0;
  int         sel = 0;

  logic       busy [2];
  logic       prdy [2];
  logic       wpv  [2];
  logic       wv   [2];
  logic       fd   [2];
  logic [7:0] wpix [2];
  logic [4:0] wrow [2];
  logic [4:0] wcol [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sliding_window_ctrl #(
    .IMG_W(W), .IMG_H(H), .PIX_W(8), .STRIDE(1)
  ) u_s1 (
    .iClk(clk), .iRst(rst), .iStart(start && sel == 0),
    .oBusy(busy[0]), .iPixelIn(pix), .iPixelValid(pv),
    .oPixelReady(prdy[0]), .oWinPixel(wpix[0]),
    .oWinPixelValid(wpv[0]), .oWinValid(wv[0]),
    .oWinRow(wrow[0]), .oWinCol(wcol[0]),
    .iWinReady(wr), .oFrameDone(fd[0])
  );

  sliding_window_ctrl #(
    .IMG_W(W), .IMG_H(H), .PIX_W(8), .STRIDE(2)
  ) u_s2 (
    .iClk(clk), .iRst(rst), .iStart(start && sel == 1),
    .oBusy(busy[1]), .iPixelIn(pix), .iPixelValid(pv),
    .oPixelReady(prdy[1]), .oWinPixel(wpix[1]),
    .oWinPixelValid(wpv[1]), .oWinValid(wv[1]),
    .oWinRow(wrow[1]), .oWinCol(wcol[1]),
    .iWinReady(wr), .oFrameDone(fd[1])
  );

  logic m_prdy;
  logic m_fd;
  assign m_prdy = prdy[sel];
  assign m_fd   = fd[sel];

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int wexp(input int s);
    return ((W - 3) / s + 1) * ((H - 3) / s + 1);
  endfunction

  // Reference model: frame phase flags plus the window that the
  // spec's position rules predict for each accepted pixel index.
  int m_s = 1;
  bit m_stream = 0;
  bit m_drain = 0;
  bit m_done = 0;
  bit m_v = 0;
  int m_r = 0;
  int m_c = 0;
  int m_k = 0;
  int m_wins = 0;
  int frames = 0;
  bit rdy, acc, nd, idle, hit;
  int r, c;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_busy", busy[sel], 0);
      check("rst_wvalid", wv[sel], 0);
      check("rst_done", fd[sel], 0);
      check("rst_ready", prdy[sel], 0);
      check("rst_wpv", wpv[sel], 0);
      check("rst_row", wrow[sel], 0);
      check("rst_col", wcol[sel], 0);
      m_stream = 0; m_drain = 0; m_done = 0; m_v = 0;
      m_r = 0; m_c = 0; m_k = 0; m_wins = 0;
    end else begin
      check("busy", busy[sel], m_stream || m_drain || m_done);
      check("frame_done", fd[sel], m_done);
      check("win_valid", wv[sel], m_v);
      if (m_v) begin
        check("win_row", wrow[sel], m_r);
        check("win_col", wcol[sel], m_c);
      end
      rdy = m_stream && !(m_v && !wr);
      check("pix_ready", prdy[sel], rdy);
      acc = pv && rdy;
      check("shift_en", wpv[sel], acc);
      if (acc) check("shift_pix", wpix[sel], m_k % 256);
      idle = !m_stream && !m_drain;
      nd = m_drain && (!m_v || wr);
      if (m_v && wr) m_wins++;
      if (m_done) begin
        check("win_count", m_wins, wexp(m_s));
        m_wins = 0;
        frames++;
      end
      if (acc) begin
        r = m_k / W;
        c = m_k % W;
        hit = r >= 2 && c >= 2
           && (r - 2) % m_s == 0 && (c - 2) % m_s == 0;
        m_v = hit;
        if (hit) begin
          m_r = (r - 2) / m_s;
          m_c = (c - 2) / m_s;
        end
        m_k++;
        if (m_k == W * H) begin
          m_stream = 0;
          m_drain = 1;
          m_k = 0;
        end
      end else if (wr) begin
        m_v = 0;
      end
      if (nd) m_drain = 0;
      m_done = nd;
      if (start && idle) m_stream = 1;
    end
  end

  task automatic run_frame(
    input int s,
    input bit gaps,
    input bit stall,
    input int rst_at,
    input bit xstart
  );
    int idx, gap, st, cyc;
    bit xfer, got, xs_done;
    @(posedge clk); #1;
    sel = (s == 2) ? 1 : 0;
    m_s = s;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    idx = 0; gap = 0; st = 0; cyc = 0; xs_done = 0;
    pv = 1; pix = 0; wr = 1;
    while (idx < W * H && cyc < 20000) begin
      @(negedge clk);
      xfer = pv && m_prdy;
      @(posedge clk); #1;
      cyc++;
      start = 0;
      if (xfer) begin
        if (stall && idx == 146) st = 5;
        idx++;
        gap = gaps ? int'($urandom_range(0, 3)) : 0;
      end
      if (rst_at > 0 && idx == rst_at) begin
        pv = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        return;
      end
      wr = (st == 0);
      if (st > 0) st--;
      if (xfer || !pv) begin
        if (gap > 0) begin
          pv = 0;
          gap--;
        end else begin
          pv = (idx < W * H);
        end
      end
      pix = idx[7:0];
      if (xstart && !xs_done && idx == 100) begin
        start = 1;
        xs_done = 1;
      end
    end
    if (cyc >= 20000) check("stream_timeout", idx, W * H);
    pv = 0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = m_fd;
    end
    check("done_seen", got, 1);
    @(posedge clk); #1;
    wr = 1;
  endtask

  initial begin
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    run_frame(1, 0, 0, 0, 1);
    run_frame(1, 1, 1, 0, 0);
    run_frame(1, 1, 0, 400, 0);
    run_frame(1, 1, 0, 0, 0);
    run_frame(2, 0, 0, 0, 0);
    run_frame(2, 1, 0, 0, 1);
    repeat (4) @(posedge clk);
    #1;
    check("frames_done", frames, 5);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
